clk_div_sched: RTL and testbench

//  Programmable clock divider with a glitch-free divisor-change scheduler.
//  Two requesters ask for a new divisor through a req/ack handshake; arbitration is round-robin.
//  A granted divisor is applied only at an output-period boundary, so clk_o never shows a runt pulse.

---
 rtl/clk_div_sched.sv | 123 ++++++++++++
 tb/tb_clk_div_sched.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_sched.sv
// Programmable clock divider with a round-robin, glitch-free divisor-change scheduler.
// Define CLKDIV_ODD_EN to accept odd divisors (>=3); otherwise odd divisors are rejected.
module clk_div_sched #(
  parameter int CW       = 8,
  parameter int DV_RESET = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic          req0,
  input  logic [CW-1:0] div0,
  output logic          ack0,
  input  logic          req1,
  input  logic [CW-1:0] div1,
  output logic          ack1,
  output logic          err,
  output logic          busy,
  output logic [CW-1:0] cur_div,
  output logic          clk_o,
  output logic          tick
);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_EDGE, DONE} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [CW-1:0] pend;
  logic          gnt;   // requester owning the transaction in flight
  logic          rr;    // requester that wins a simultaneous request

  logic [CW-1:0] hi_len, lo_len, hi_term, lo_term, term;
  logic          fall, boundary, pend_ok, pick;

  // Odd divisors put the extra cycle in the high phase.
`ifdef CLKDIV_ODD_EN
  assign hi_len  = cur_div - (cur_div >> 1);
  assign pend_ok = (pend >= CW'(2));
`else
  assign hi_len  = cur_div >> 1;
  assign pend_ok = (pend >= CW'(2)) && !pend[0];
`endif
  assign lo_len   = cur_div >> 1;
  assign hi_term  = hi_len - CW'(1);
  assign lo_term  = lo_len - CW'(1);
  assign term     = clk_o ? hi_term : lo_term;
  assign fall     = en && clk_o && (count == hi_term);
  assign boundary = !en || fall;
  assign pick     = (req0 && req1) ? rr : req1;

  // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      count   <= '0;
      pend    <= '0;
      gnt     <= 1'b0;
      rr      <= 1'b0;
      cur_div <= CW'(DV_RESET);
      clk_o   <= 1'b0;
      tick    <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err  <= 1'b0;

      if (!en) begin
        count <= '0;
        clk_o <= 1'b0;
        tick  <= clk_o;
      end else if (count == term) begin
        count <= '0;
        clk_o <= !clk_o;
        tick  <= clk_o;
      end else begin
        count <= count + CW'(1);
        tick  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt   <= pick;
            pend  <= pick ? div1 : div0;
            rr    <= !pick;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (pend_ok) begin
            state <= WAIT_EDGE;
          end else begin
            err   <= 1'b1;
            ack0  <= !gnt;
            ack1  <= gnt;
            state <= DONE;
          end
        end
        WAIT_EDGE: begin
          // Switching here never shortens a phase: the old high phase has just completed.
          if (boundary) begin
            cur_div <= pend;
            count   <= '0;
            clk_o   <= 1'b0;
            ack0    <= !gnt;
            ack1    <= gnt;
            state   <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed bench for clk_div_sched: divider waveform, handshake latency, arbitration, reset abort.
module tb_clk_div_sched;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rstn, en, req0, req1;
  logic [CW-1:0] div0, div1;
  logic          ack0, ack1, err, busy, clk_o, tick;
  logic [CW-1:0] cur_div;

  int n_vec = 0;
  int n_err = 0;

  clk_div_sched #(.CW(CW), .DV_RESET(4)) dut (
    .clk(clk), .rstn(rstn), .en(en),
    .req0(req0), .div0(div0), .ack0(ack0),
    .req1(req1), .div1(div1), .ack1(ack1),
    .err(err), .busy(busy), .cur_div(cur_div),
    .clk_o(clk_o), .tick(tick)
  );

  always #5 clk = !clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    logic got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      step();
      got = tick;
    end
    check("wait_tick_timeout", {31'd0, !got}, 0);
  endtask

  // Call on a tick sample; counts low and high samples up to the next tick.
  task automatic meas(output int lo, output int hi);
    logic done = 1'b0;
    lo = 1;
    hi = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      if (tick) done = 1'b1;
      else if (clk_o) hi++;
      else lo++;
    end
    check("meas_timeout", {31'd0, !done}, 0);
  endtask

  task automatic wait_ack(input logic which, output int n, output logic other);
    logic got = 1'b0;
    n = 0;
    other = 1'b0;
    while (!got && n < 60) begin
      step();
      n++;
      got = which ? ack1 : ack0;
      if (which ? ack0 : ack1) other = 1'b1;
    end
    check("wait_ack_timeout", {31'd0, !got}, 0);
  endtask

  initial begin
    logic [7:0] exp_clk = 8'b0110_0110;
    logic [7:0] exp_tck = 8'b1000_1000;
    int lo, hi, n;
    logic other, any_ack;

    rstn = 1'b0; en = 1'b0; req0 = 1'b0; req1 = 1'b0; div0 = '0; div1 = '0;
    step(); step();

    // T1: reset state, then divide-by-4 waveform
    check("rst_clk_o", clk_o, 0);
    check("rst_tick", tick, 0);
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_cur_div", cur_div, 4);
    rstn = 1'b1; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("t1_clk_o_%0d", i), clk_o, exp_clk[i]);
      check($sformatf("t1_tick_%0d", i), tick, exp_tck[i]);
    end

    // T2: request 6 on a tick sample; switch lands on the next falling edge
    req0 = 1'b1; div0 = 8'd6;
    step(); step(); step();
    check("t2_cur_div_hold", cur_div, 4);
    check("t2_busy", busy, 1);
    check("t2_no_early_ack", ack0, 0);
    check("t2_high_intact", clk_o, 1);
    step();
    check("t2_ack0", ack0, 1);
    check("t2_err", err, 0);
    check("t2_tick_on_switch", tick, 1);
    check("t2_clk_o_low", clk_o, 0);
    check("t2_cur_div", cur_div, 6);
    req0 = 1'b0;
    step();
    check("t2_ack_pulse", ack0, 0);
    check("t2_idle", busy, 0);
    wait_tick();
    meas(lo, hi);
    check("t2_lo", lo, 3);
    check("t2_hi", hi, 3);

    // T3: fresh pointer, simultaneous requests -> requester 0 then 1
    rstn = 1'b0; step(); rstn = 1'b1;
    req0 = 1'b1; div0 = 8'd8; req1 = 1'b1; div1 = 8'd10;
    wait_ack(1'b0, n, other);
    check("t3_first_is_0", other, 0);
    check("t3_div_after_0", cur_div, 8);
    check("t3_err0", err, 0);
    req0 = 1'b0;
    wait_ack(1'b1, n, other);
    check("t3_div_after_1", cur_div, 10);
    check("t3_err1", err, 0);
    req1 = 1'b0;
    req0 = 1'b1; div0 = 8'd4;
    wait_ack(1'b0, n, other);
    check("t3_single_div", cur_div, 4);
    req0 = 1'b0;
    step();
    req0 = 1'b1; div0 = 8'd6; req1 = 1'b1; div1 = 8'd8;
    wait_ack(1'b1, n, other);
    check("t3_rr_first_is_1", other, 0);
    check("t3_rr_div_1", cur_div, 8);
    req1 = 1'b0;
    wait_ack(1'b0, n, other);
    check("t3_rr_div_0", cur_div, 6);
    req0 = 1'b0;
    step();

    // T4: odd divisor
    req0 = 1'b1; div0 = 8'd5;
    wait_ack(1'b0, n, other);
    req0 = 1'b0;
`ifdef CLKDIV_ODD_EN
    check("t4_err_odd_ok", err, 0);
    check("t4_cur_div", cur_div, 5);
    check("t4_switch_tick", tick, 1);
    meas(lo, hi);
    check("t4_lo", lo, 2);
    check("t4_hi", hi, 3);
`else
    check("t4_err_odd", err, 1);
    check("t4_latency", n, 2);
    check("t4_cur_div", cur_div, 6);
`endif
    step();

    // T5: divisors 0 and 1 are rejected in exactly 2 cycles
    req0 = 1'b1; div0 = 8'd0;
    wait_ack(1'b0, n, other);
    req0 = 1'b0;
    check("t5_div0_err", err, 1);
    check("t5_div0_lat", n, 2);
    step();
    req0 = 1'b1; div0 = 8'd1;
    wait_ack(1'b0, n, other);
    req0 = 1'b0;
    check("t5_div1_err", err, 1);
    check("t5_div1_lat", n, 2);
    step();
    en = 1'b0; req1 = 1'b1; div1 = 8'd12;
    wait_ack(1'b1, n, other);
    req1 = 1'b0;
    check("t5_en0_lat", n, 3);
    check("t5_en0_err", err, 0);
    check("t5_en0_div", cur_div, 12);
    check("t5_en0_clk_o", clk_o, 0);
    en = 1'b1;
    wait_tick();
    meas(lo, hi);
    check("t5_lo", lo, 6);
    check("t5_hi", hi, 6);

    // T6: reset while waiting for the boundary
    req0 = 1'b1; div0 = 8'd8;
    step(); step(); step();
    check("t6_busy_wait", busy, 1);
    rstn = 1'b0; req0 = 1'b0;
    step();
    rstn = 1'b1;
    check("t6_busy", busy, 0);
    check("t6_cur_div", cur_div, 4);
    check("t6_clk_o", clk_o, 0);
    any_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (ack0 || ack1) any_ack = 1'b1;
    end
    check("t6_no_ack", any_ack, 0);
    wait_tick();
    meas(lo, hi);
    check("t6_lo", lo, 2);
    check("t6_hi", hi, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
